id_ex_stage: RTL and testbench

ID/EX pipeline stage of the 5-stage MIPS core, directly downstream of the decode-side immediate extender. It registers the extended immediate, register-file operands and decoded control into the EX stage. It detects load-use hazards against the instruction currently in EX, requests an upstream stall, and inserts bubbles. It also honours an EX-resolved branch flush, a downstream memory stall, and keeps a saturating bubble counter for performance debug.

---
 rtl/mips_pkg.sv | 48 ++++
 rtl/load_use_detect.sv | 26 ++
 rtl/id_ex_stage.sv | 140 ++++++++++++++
 tb/tb_id_ex_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline stages.
package mips_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int ALUOP_W = 4;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // Decoded control that travels with an instruction down the pipe.
  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Full ID/EX pipeline register contents.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dst;
    ctrl_t             ctrl;
  } idex_t;

  // A bubble is all-zero so it can never write a register or memory.
  localparam idex_t IDEX_BUBBLE = '{
    valid:   1'b0,
    pc:      '0,
    imm:     '0,
    rs_data: '0,
    rt_data: '0,
    rs:      '0,
    rt:      '0,
    dst:     '0,
    ctrl:    CTRL_BUBBLE
  };

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: the instruction in ID reads a register that the
// load currently in EX has not produced yet. Loads to $0 are harmless.
module load_use_detect
  import mips_pkg::*;
(
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_dst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rs_i,
  input  logic              id_uses_rt_i,
  output logic              load_use_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs_i & (id_rs_i == ex_dst_i);
  assign rt_hit = id_uses_rt_i & (id_rt_i == ex_dst_i);

  assign load_use_o = ex_valid_i & ex_mem_read_i & (ex_dst_i != REG_ZERO)
                    & id_valid_i & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush, memory-stall
// hold and a saturating bubble counter.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_pc,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic [REG_AW-1:0]  id_dst,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic               id_alu_src,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               ex_flush,
  input  logic               mem_stall,
  output logic               id_stall,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_pc,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [DATA_W-1:0]  ex_rs_data,
  output logic [DATA_W-1:0]  ex_rt_data,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic [REG_AW-1:0]  ex_dst,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic               ex_alu_src,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [CNT_W-1:0]   bubble_count
);

  idex_t            ex_q, ex_d;
  idex_t            id_bundle;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             count_bubble;
  logic             load_use;

  assign id_bundle = '{
    valid:   1'b1,
    pc:      id_pc,
    imm:     id_imm,
    rs_data: id_rs_data,
    rt_data: id_rt_data,
    rs:      id_rs,
    rt:      id_rt,
    dst:     id_dst,
    ctrl:    '{reg_write:  id_reg_write,
               mem_read:   id_mem_read,
               mem_write:  id_mem_write,
               mem_to_reg: id_mem_to_reg,
               alu_src:    id_alu_src,
               alu_op:     id_alu_op}
  };

  load_use_detect u_load_use_detect (
    .ex_valid_i    (ex_q.valid),
    .ex_mem_read_i (ex_q.ctrl.mem_read),
    .ex_dst_i      (ex_q.dst),
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_uses_rs_i  (id_uses_rs),
    .id_uses_rt_i  (id_uses_rt),
    .load_use_o    (load_use)
  );

  // A flushed ID instruction is discarded upstream, so flush releases the stall.
  assign id_stall = ~reset & ~ex_flush & (mem_stall | load_use);

  // Next EX contents by priority: flush, memory hold, load-use bubble, capture.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    ex_d         = ex_q;
    count_bubble = 1'b0;
    if (ex_flush) begin
      ex_d         = IDEX_BUBBLE;
      count_bubble = 1'b1;
    end else if (mem_stall) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d         = IDEX_BUBBLE;
      count_bubble = 1'b1;
    end else if (id_valid) begin
      ex_d = id_bundle;
    end else begin
      ex_d = IDEX_BUBBLE;
    end
  end

  // Saturating bubble counter: holds at all-ones instead of wrapping.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (count_bubble && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  // Pipeline register and counter with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      ex_q         <= IDEX_BUBBLE;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_pc         = ex_q.pc;
  assign ex_imm        = ex_q.imm;
  assign ex_rs_data    = ex_q.rs_data;
  assign ex_rt_data    = ex_q.rt_data;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_dst        = ex_q.dst;
  assign ex_reg_write  = ex_q.ctrl.reg_write;
  assign ex_mem_read   = ex_q.ctrl.mem_read;
  assign ex_mem_write  = ex_q.ctrl.mem_write;
  assign ex_mem_to_reg = ex_q.ctrl.mem_to_reg;
  assign ex_alu_src    = ex_q.ctrl.alu_src;
  assign ex_alu_op     = ex_q.ctrl.alu_op;
  assign bubble_count  = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a behavioural model of the EX register
// checked every cycle, plus literal expectations at the interesting points.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc, id_imm, id_rs_data, id_rt_data;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic        id_uses_rs, id_uses_rt;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src;
  logic [3:0]  id_alu_op;
  logic        ex_flush, mem_stall;

  logic        id_stall, ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_rs_data, ex_rt_data;
  logic [4:0]  ex_rs, ex_rt, ex_dst;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
  logic [3:0]  ex_alu_op;
  logic [15:0] bubble_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .ex_flush(ex_flush), .mem_stall(mem_stall), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .bubble_count(bubble_count)
  );

  // Model of what EX should hold; an all-zero record is a bubble.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, imm, rsd, rtd;
    logic [4:0]  rs, rt, dst;
    logic        rw, mr, mw, m2r, as;
    logic [3:0]  op;
  } ex_rec_t;

  ex_rec_t m;
  int      m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_load_use();
    return m.valid && m.mr && (m.dst != 5'd0) && id_valid &&
           ((id_uses_rs && id_rs == m.dst) || (id_uses_rt && id_rt == m.dst));
  endfunction

  function automatic logic model_stall();
    return !reset && !ex_flush && (mem_stall || model_load_use());
  endfunction

  task automatic compare();
    check("id_stall",      {31'd0, id_stall},      {31'd0, model_stall()});
    check("ex_valid",      {31'd0, ex_valid},      {31'd0, m.valid});
    check("ex_pc",         ex_pc,                  m.pc);
    check("ex_imm",        ex_imm,                 m.imm);
    check("ex_rs_data",    ex_rs_data,             m.rsd);
    check("ex_rt_data",    ex_rt_data,             m.rtd);
    check("ex_rs",         {27'd0, ex_rs},         {27'd0, m.rs});
    check("ex_rt",         {27'd0, ex_rt},         {27'd0, m.rt});
    check("ex_dst",        {27'd0, ex_dst},        {27'd0, m.dst});
    check("ex_reg_write",  {31'd0, ex_reg_write},  {31'd0, m.rw});
    check("ex_mem_read",   {31'd0, ex_mem_read},   {31'd0, m.mr});
    check("ex_mem_write",  {31'd0, ex_mem_write},  {31'd0, m.mw});
    check("ex_mem_to_reg", {31'd0, ex_mem_to_reg}, {31'd0, m.m2r});
    check("ex_alu_src",    {31'd0, ex_alu_src},    {31'd0, m.as});
    check("ex_alu_op",     {28'd0, ex_alu_op},     {28'd0, m.op});
    check("bubble_count",  {16'd0, bubble_count},  m_cnt);
  endtask

  // What the clock edge must do given the inputs now on the pins.
  task automatic model_step();
    logic bubble, count, hold;
    bubble = 1'b0; count = 1'b0; hold = 1'b0;
    if (reset) begin
      m = '0;
      m_cnt = 0;
      return;
    end
    if (ex_flush)               begin bubble = 1'b1; count = 1'b1; end
    else if (mem_stall)         hold = 1'b1;
    else if (model_load_use())  begin bubble = 1'b1; count = 1'b1; end
    else if (!id_valid)         bubble = 1'b1;
    if (count && m_cnt < 65535) m_cnt = m_cnt + 1;
    if (bubble) m = '0;
    else if (!hold)
      m = '{valid: 1'b1, pc: id_pc, imm: id_imm, rsd: id_rs_data, rtd: id_rt_data,
            rs: id_rs, rt: id_rt, dst: id_dst, rw: id_reg_write, mr: id_mem_read,
            mw: id_mem_write, m2r: id_mem_to_reg, as: id_alu_src, op: id_alu_op};
  endtask

  // One cycle: check at the falling edge, advance the model, let the edge pass.
  task automatic tick();
    @(negedge clk);
    compare();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_pc = '0; id_imm = '0; id_rs_data = '0; id_rt_data = '0;
    id_rs = '0; id_rt = '0; id_dst = '0; id_uses_rs = 0; id_uses_rt = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    id_alu_src = 0; id_alu_op = '0; ex_flush = 0; mem_stall = 0;
  endtask

  task automatic set_lw(input logic [4:0] dst, input logic [31:0] pc);
    idle();
    id_valid = 1; id_pc = pc; id_imm = 32'h0000_0010; id_rs = 5'd29; id_uses_rs = 1;
    id_dst = dst; id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1; id_alu_src = 1;
    id_alu_op = 4'h2; id_rs_data = 32'h1000_0000;
  endtask

  task automatic set_alu(input logic [4:0] rs, input logic use_rs, input logic [4:0] rt,
                         input logic use_rt, input logic [4:0] dst, input logic [31:0] pc);
    idle();
    id_valid = 1; id_pc = pc; id_rs = rs; id_uses_rs = use_rs; id_rt = rt; id_uses_rt = use_rt;
    id_dst = dst; id_reg_write = 1; id_alu_op = 4'h5;
    id_rs_data = 32'hA5A5_0001; id_rt_data = 32'h5A5A_0002;
  endtask

  initial begin
    m = '0;
    m_cnt = 0;
    idle();
    // Reset with a live instruction on the ID inputs.
    reset = 1; id_valid = 1; id_imm = 32'hFFFF_8000;
    @(posedge clk); #1;
    tick();
    check("rst ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst ex_imm", ex_imm, 32'd0);
    check("rst bubble_count", {16'd0, bubble_count}, 32'd0);
    check("rst id_stall", {31'd0, id_stall}, 32'd0);

    // Normal flow.
    reset = 0;
    idle();
    id_valid = 1; id_pc = 32'h0040_0004; id_imm = 32'h0012_0000; id_dst = 5'd8; id_reg_write = 1;
    tick();
    check("norm ex_pc", ex_pc, 32'h0040_0004);
    check("norm ex_imm", ex_imm, 32'h0012_0000);
    check("norm ex_dst", {27'd0, ex_dst}, 32'd8);
    check("norm ex_valid", {31'd0, ex_valid}, 32'd1);

    // Load-use on rs: one stall cycle, one bubble, then the consumer enters EX.
    set_lw(5'd9, 32'h0040_0008);
    tick();
    set_alu(5'd9, 1, 5'd10, 1, 5'd11, 32'h0040_000C);
    #1 check("lu stall", {31'd0, id_stall}, 32'd1);
    tick();
    check("lu bubble", {31'd0, ex_valid}, 32'd0);
    check("lu count", {16'd0, bubble_count}, 32'd1);
    check("lu released", {31'd0, id_stall}, 32'd0);
    tick();
    check("lu consumer dst", {27'd0, ex_dst}, 32'd11);
    check("lu consumer pc", ex_pc, 32'h0040_000C);

    // No false stall: load to $0, and an unused rt match.
    set_lw(5'd0, 32'h0040_0010);
    tick();
    set_alu(5'd0, 1, 5'd0, 1, 5'd12, 32'h0040_0014);
    #1 check("zero no stall", {31'd0, id_stall}, 32'd0);
    tick();
    check("zero no bubble", {31'd0, ex_valid}, 32'd1);
    set_lw(5'd9, 32'h0040_0018);
    tick();
    set_alu(5'd3, 1, 5'd9, 0, 5'd13, 32'h0040_001C);
    #1 check("rt unused no stall", {31'd0, id_stall}, 32'd0);
    tick();
    check("rt unused count", {16'd0, bubble_count}, 32'd1);

    // Flush together with an active load-use.
    set_lw(5'd9, 32'h0040_0020);
    tick();
    set_alu(5'd9, 1, 5'd0, 0, 5'd14, 32'h0040_0024);
    ex_flush = 1;
    #1 check("flush stall", {31'd0, id_stall}, 32'd0);
    tick();
    check("flush bubble", {31'd0, ex_valid}, 32'd0);
    check("flush count", {16'd0, bubble_count}, 32'd2);

    // Memory stall holds EX for three cycles.
    set_alu(5'd1, 1, 5'd2, 1, 5'd3, 32'h0000_0100);
    tick();
    set_alu(5'd4, 1, 5'd5, 1, 5'd6, 32'h0000_0200);
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("mstall id_stall", {31'd0, id_stall}, 32'd1);
      tick();
      check("mstall hold pc", ex_pc, 32'h0000_0100);
    end
    mem_stall = 0;
    tick();
    check("mstall release pc", ex_pc, 32'h0000_0200);

    // Idle ID gives an uncounted bubble.
    idle();
    tick();
    check("idle bubble", {31'd0, ex_valid}, 32'd0);
    check("idle count", {16'd0, bubble_count}, 32'd2);

    // Reset in the middle of a load-use stall.
    set_lw(5'd9, 32'h0040_0030);
    tick();
    set_alu(5'd9, 1, 5'd0, 0, 5'd15, 32'h0040_0034);
    reset = 1;
    #1 check("rst stall released", {31'd0, id_stall}, 32'd0);
    tick();
    check("rst mid valid", {31'd0, ex_valid}, 32'd0);
    check("rst mid count", {16'd0, bubble_count}, 32'd0);
    reset = 0;

    // Saturation: 65535 flushes reach all-ones, the next one holds it there.
    idle();
    ex_flush = 1;
    repeat (65535) tick();
    check("sat reach", {16'd0, bubble_count}, 32'h0000_FFFF);
    tick();
    check("sat hold", {16'd0, bubble_count}, 32'h0000_FFFF);
    ex_flush = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
